// File: rtl/cr_pmp_perm_chk.sv
// PMP permission check: lowest-index hit wins, R/W/X/L rules applied,
// and one registered fault result per port behind a valid/ready handshake.
module cr_pmp_perm_chk #(
    parameter int NUM_ENTRY = 8,
    parameter int IDX_W     = 4
) (
    input  logic                 pmp_clk,
    input  logic                 cpurst_b,
    input  logic                 cp0_pmp_mach_mode,
    input  logic [NUM_ENTRY-1:0] pmpcfg_r,
    input  logic [NUM_ENTRY-1:0] pmpcfg_w,
    input  logic [NUM_ENTRY-1:0] pmpcfg_x,
    input  logic [NUM_ENTRY-1:0] pmpcfg_l,
    input  logic                 ifu_pmp_req_vld,
    input  logic [NUM_ENTRY-1:0] pmp_ifu_hit_vec,
    output logic                 pmp_ifu_req_rdy,
    output logic                 pmp_ifu_rslt_vld,
    output logic                 pmp_ifu_fault,
    input  logic                 ifu_pmp_rslt_rdy,
    input  logic                 lsu_pmp_req_vld,
    input  logic                 lsu_pmp_req_st,
    input  logic [NUM_ENTRY-1:0] pmp_lsu_hit_vec,
    output logic                 pmp_lsu_req_rdy,
    output logic                 pmp_lsu_rslt_vld,
    output logic                 pmp_lsu_fault,
    output logic                 pmp_lsu_fault_st,
    output logic [IDX_W-1:0]     pmp_lsu_hit_idx,
    input  logic                 lsu_pmp_rslt_rdy
);

    logic             ifu_hit;
    logic             ifu_perm;
    logic             ifu_lock;
    logic             ifu_fault_d;
    logic             ifu_acc;
    logic             ifu_vld_q;
    logic             ifu_fault_q;

    logic             lsu_hit;
    logic             lsu_perm;
    logic             lsu_lock;
    logic [IDX_W-1:0] lsu_idx_d;
    logic             lsu_fault_d;
    logic             lsu_acc;
    logic             lsu_vld_q;
    logic             lsu_fault_q;
    logic             lsu_st_q;
    logic [IDX_W-1:0] lsu_idx_q;

    // Descending scan so the lowest matching index is the last to assign.
    always_comb begin
        ifu_hit  = 1'b0;
        ifu_perm = 1'b0;
        ifu_lock = 1'b0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (pmp_ifu_hit_vec[i]) begin
                ifu_hit  = 1'b1;
                ifu_perm = pmpcfg_x[i];
                ifu_lock = pmpcfg_l[i];
            end
        end
        if (!ifu_hit) begin
            ifu_fault_d = !cp0_pmp_mach_mode;
        end else if (cp0_pmp_mach_mode) begin
            ifu_fault_d = ifu_lock && !ifu_perm;
        end else begin
            ifu_fault_d = !ifu_perm;
        end
    end

    always_comb begin
        lsu_hit   = 1'b0;
        lsu_perm  = 1'b0;
        lsu_lock  = 1'b0;
        lsu_idx_d = '1;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (pmp_lsu_hit_vec[i]) begin
                lsu_hit   = 1'b1;
                lsu_perm  = lsu_pmp_req_st ? pmpcfg_w[i] : pmpcfg_r[i];
                lsu_lock  = pmpcfg_l[i];
                lsu_idx_d = IDX_W'(i);
            end
        end
        if (!lsu_hit) begin
            lsu_fault_d = !cp0_pmp_mach_mode;
        end else if (cp0_pmp_mach_mode) begin
            lsu_fault_d = lsu_lock && !lsu_perm;
        end else begin
            lsu_fault_d = !lsu_perm;
        end
    end

    assign pmp_ifu_req_rdy = !ifu_vld_q || ifu_pmp_rslt_rdy;
    assign pmp_lsu_req_rdy = !lsu_vld_q || lsu_pmp_rslt_rdy;
    assign ifu_acc         = ifu_pmp_req_vld && pmp_ifu_req_rdy;
    assign lsu_acc         = lsu_pmp_req_vld && pmp_lsu_req_rdy;

    always_ff @(posedge pmp_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ifu_vld_q   <= 1'b0;
            ifu_fault_q <= 1'b0;
        end else if (ifu_acc) begin
            ifu_vld_q   <= 1'b1;
            ifu_fault_q <= ifu_fault_d;
        end else if (ifu_pmp_rslt_rdy) begin
            ifu_vld_q   <= 1'b0;
        end
    end

    always_ff @(posedge pmp_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            lsu_vld_q   <= 1'b0;
            lsu_fault_q <= 1'b0;
            lsu_st_q    <= 1'b0;
            lsu_idx_q   <= '1;
        end else if (lsu_acc) begin
            lsu_vld_q   <= 1'b1;
            lsu_fault_q <= lsu_fault_d;
            lsu_st_q    <= lsu_pmp_req_st;
            lsu_idx_q   <= lsu_idx_d;
        end else if (lsu_pmp_rslt_rdy) begin
            lsu_vld_q   <= 1'b0;
        end
    end

    assign pmp_ifu_rslt_vld = ifu_vld_q;
    assign pmp_ifu_fault    = ifu_fault_q;
    assign pmp_lsu_rslt_vld = lsu_vld_q;
    assign pmp_lsu_fault    = lsu_fault_q;
    assign pmp_lsu_fault_st = lsu_st_q;
    assign pmp_lsu_hit_idx  = lsu_idx_q;

endmodule

// File: tb/tb_cr_pmp_perm_chk.sv
// Directed bench for cr_pmp_perm_chk.
module tb_cr_pmp_perm_chk;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       mach;
    logic [7:0] cfg_r, cfg_w, cfg_x, cfg_l;
    logic       ifu_vld;
    logic [7:0] ifu_hit;
    logic       ifu_rdy_o;
    logic       ifu_rvld;
    logic       ifu_flt;
    logic       ifu_rrdy;
    logic       lsu_vld;
    logic       lsu_st;
    logic [7:0] lsu_hit;
    logic       lsu_rdy_o;
    logic       lsu_rvld;
    logic       lsu_flt;
    logic       lsu_fst;
    logic [3:0] lsu_idx;
    logic       lsu_rrdy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cr_pmp_perm_chk #(.NUM_ENTRY(8), .IDX_W(4)) dut (
        .pmp_clk          (clk),
        .cpurst_b         (rst_b),
        .cp0_pmp_mach_mode(mach),
        .pmpcfg_r         (cfg_r),
        .pmpcfg_w         (cfg_w),
        .pmpcfg_x         (cfg_x),
        .pmpcfg_l         (cfg_l),
        .ifu_pmp_req_vld  (ifu_vld),
        .pmp_ifu_hit_vec  (ifu_hit),
        .pmp_ifu_req_rdy  (ifu_rdy_o),
        .pmp_ifu_rslt_vld (ifu_rvld),
        .pmp_ifu_fault    (ifu_flt),
        .ifu_pmp_rslt_rdy (ifu_rrdy),
        .lsu_pmp_req_vld  (lsu_vld),
        .lsu_pmp_req_st   (lsu_st),
        .pmp_lsu_hit_vec  (lsu_hit),
        .pmp_lsu_req_rdy  (lsu_rdy_o),
        .pmp_lsu_rslt_vld (lsu_rvld),
        .pmp_lsu_fault    (lsu_flt),
        .pmp_lsu_fault_st (lsu_fst),
        .pmp_lsu_hit_idx  (lsu_idx),
        .lsu_pmp_rslt_rdy (lsu_rrdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; mach = 1'b1;
        cfg_r = '0; cfg_w = '0; cfg_x = '0; cfg_l = '0;
        ifu_vld = 0; ifu_hit = '0; ifu_rrdy = 1;
        lsu_vld = 0; lsu_st = 0; lsu_hit = '0; lsu_rrdy = 1;
        repeat (3) tick();
        rst_b = 1'b1;
        #1;
        checks++;
        if (ifu_rdy_o !== 1'b1) begin failures++;
            $display("FAIL reset_ifu_rdy got=%b exp=1", ifu_rdy_o); end
        checks++;
        if (lsu_rdy_o !== 1'b1) begin failures++;
            $display("FAIL reset_lsu_rdy got=%b exp=1", lsu_rdy_o); end
        checks++;
        if ({ifu_rvld, lsu_rvld} !== 2'b00) begin failures++;
            $display("FAIL reset_vld got=%b exp=00", {ifu_rvld, lsu_rvld}); end
        checks++;
        if (lsu_idx !== 4'hF) begin failures++;
            $display("FAIL reset_idx got=%h exp=f", lsu_idx); end
        checks++;
        if ({ifu_flt, lsu_flt, lsu_fst} !== 3'b000) begin failures++;
            $display("FAIL reset_fault got=%b exp=000", {ifu_flt, lsu_flt, lsu_fst}); end
    endtask

    task automatic test_priority();
        mach = 0; cfg_r = 8'b0000_0100; cfg_l = '0;
        lsu_vld = 1; lsu_st = 0; lsu_hit = 8'b0000_0110; lsu_rrdy = 1;
        tick();
        lsu_hit = 8'b0000_0100;
        checks++;
        if ({lsu_rvld, lsu_flt, lsu_idx} !== {1'b1, 1'b1, 4'd1}) begin failures++;
            $display("FAIL prio_lo got=%b%b/%h exp=11/1", lsu_rvld, lsu_flt, lsu_idx); end
        tick();
        lsu_vld = 0;
        checks++;
        if ({lsu_rvld, lsu_flt, lsu_idx} !== {1'b1, 1'b0, 4'd2}) begin failures++;
            $display("FAIL prio_e2 got=%b%b/%h exp=10/2", lsu_rvld, lsu_flt, lsu_idx); end
        tick();
        checks++;
        if (lsu_rvld !== 1'b0) begin failures++;
            $display("FAIL prio_drain got=%b exp=0", lsu_rvld); end
    endtask

    task automatic test_lock();
        mach = 1; cfg_x = 8'b1111_0111; cfg_l = 8'b0000_0000;
        ifu_vld = 1; ifu_hit = 8'b0000_1000; ifu_rrdy = 1;
        tick();
        cfg_l = 8'b0000_1000;
        checks++;
        if ({ifu_rvld, ifu_flt} !== 2'b10) begin failures++;
            $display("FAIL lock_off got=%b exp=10", {ifu_rvld, ifu_flt}); end
        tick();
        cfg_x = 8'b0000_1000;
        checks++;
        if ({ifu_rvld, ifu_flt} !== 2'b11) begin failures++;
            $display("FAIL lock_on got=%b exp=11", {ifu_rvld, ifu_flt}); end
        tick();
        mach = 0; cfg_x = 8'b0000_0000; cfg_l = '0;
        checks++;
        if ({ifu_rvld, ifu_flt} !== 2'b10) begin failures++;
            $display("FAIL lock_x got=%b exp=10", {ifu_rvld, ifu_flt}); end
        tick();
        ifu_vld = 0;
        checks++;
        if ({ifu_rvld, ifu_flt} !== 2'b11) begin failures++;
            $display("FAIL umode_nox got=%b exp=11", {ifu_rvld, ifu_flt}); end
        tick();
    endtask

    task automatic test_nomatch();
        mach = 1; ifu_vld = 1; ifu_hit = '0;
        lsu_vld = 1; lsu_hit = '0; lsu_st = 1; cfg_w = 8'hFF;
        tick();
        mach = 0;
        checks++;
        if ({ifu_rvld, ifu_flt} !== 2'b10) begin failures++;
            $display("FAIL nm_m_ifu got=%b exp=10", {ifu_rvld, ifu_flt}); end
        checks++;
        if ({lsu_flt, lsu_fst, lsu_idx} !== {1'b0, 1'b1, 4'hF}) begin failures++;
            $display("FAIL nm_m_lsu got=%b%b/%h exp=01/f", lsu_flt, lsu_fst, lsu_idx); end
        tick();
        ifu_vld = 0; lsu_vld = 0;
        checks++;
        if ({lsu_rvld, lsu_flt, lsu_fst, lsu_idx} !== {3'b111, 4'hF}) begin failures++;
            $display("FAIL nm_u_st got=%b%b%b/%h exp=111/f", lsu_rvld, lsu_flt, lsu_fst, lsu_idx); end
        checks++;
        if (ifu_flt !== 1'b1) begin failures++;
            $display("FAIL nm_u_ifu got=%b exp=1", ifu_flt); end
        tick();
    endtask

    task automatic test_back_to_back();
        mach = 0; cfg_w = 8'h01; cfg_r = 8'h00; cfg_l = '0;
        lsu_vld = 1; lsu_st = 1; lsu_hit = 8'b0000_0001; lsu_rrdy = 0;
        tick();
        for (int c = 0; c < 3; c++) begin
            cfg_w = ~cfg_w;
            mach = ~mach;
            #1;
            checks++;
            if ({lsu_rvld, lsu_flt, lsu_fst, lsu_idx, lsu_rdy_o} !== {3'b101, 4'd0, 1'b0}) begin
                failures++;
                $display("FAIL hold_%0d got=%b%b%b/%h rdy=%b exp=101/0 rdy=0",
                         c, lsu_rvld, lsu_flt, lsu_fst, lsu_idx, lsu_rdy_o);
            end
            tick();
        end
        mach = 0; lsu_st = 0; lsu_rrdy = 1; cfg_r = 8'h00;
        #1;
        checks++;
        if (lsu_rdy_o !== 1'b1) begin failures++;
            $display("FAIL b2b_rdy got=%b exp=1", lsu_rdy_o); end
        tick();
        lsu_vld = 0;
        checks++;
        if ({lsu_rvld, lsu_flt, lsu_fst} !== 3'b110) begin failures++;
            $display("FAIL b2b_new got=%b exp=110", {lsu_rvld, lsu_flt, lsu_fst}); end
        tick();
        checks++;
        if (lsu_rvld !== 1'b0) begin failures++;
            $display("FAIL b2b_clear got=%b exp=0", lsu_rvld); end
    endtask

    task automatic test_async_reset();
        mach = 0; cfg_x = '0; cfg_r = '0;
        ifu_vld = 1; ifu_hit = 8'h01; ifu_rrdy = 0;
        lsu_vld = 1; lsu_hit = 8'h80; lsu_st = 0; lsu_rrdy = 0;
        tick();
        ifu_vld = 0; lsu_vld = 0;
        checks++;
        if ({ifu_rvld, ifu_flt, lsu_rvld, lsu_flt, lsu_idx} !== {4'b1111, 4'd7}) begin
            failures++;
            $display("FAIL ar_pre got=%b%b%b%b/%h exp=1111/7",
                     ifu_rvld, ifu_flt, lsu_rvld, lsu_flt, lsu_idx);
        end
        #2;
        rst_b = 0;
        #1;
        checks++;
        if ({ifu_rvld, ifu_flt, lsu_rvld, lsu_flt, lsu_idx} !== {4'b0000, 4'hF}) begin
            failures++;
            $display("FAIL ar_drop got=%b%b%b%b/%h exp=0000/f",
                     ifu_rvld, ifu_flt, lsu_rvld, lsu_flt, lsu_idx);
        end
        tick();
        rst_b = 1;
        tick();
        checks++;
        if ({ifu_rvld, lsu_rvld, ifu_rdy_o} !== 3'b001) begin failures++;
            $display("FAIL ar_post got=%b exp=001", {ifu_rvld, lsu_rvld, ifu_rdy_o}); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lock();
        test_nomatch();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
